ps2_scan_decoder: RTL and testbench

Host-side PS/2 keyboard receiver. It is the producer of the 11-bit ps2_key event bus that the keyboard matrix block consumes.
- Synchronises and filters the raw ps2_clk/ps2_data lines.
- Deserialises 11-bit device frames.
- Folds the scan-code set 2 prefixes (E0 extended, F0 break, E1 pause) into single key events.
- Emits one strobed event per key make or break.

---
 rtl/ps2_scan_decoder.sv | 134 +++++++++++++
 tb/tb_ps2_scan_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: PS/2 keyboard receiver folding scan-set-2 prefixes into strobed key events.
module ps2_scan_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 12500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        rx_err,
  output logic [7:0]  diag
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;
  logic [1:0]    clk_s, dat_s;
  logic          clk_f, dat_f, clk_d;
  logic [FW-1:0] clk_c, dat_c;
  logic [1:0]    state;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          byte_valid;
  logic          ext, brk;
  logic [2:0]    skip;
  logic          fall, timeout, stop_ok, stop_bad, ignored;
  always_comb begin
    fall     = clk_d & ~clk_f;
    timeout  = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC));
    stop_ok  = dat_f & (^{shreg, par});
    stop_bad = fall && (state == STOP) && !stop_ok;
    ignored  = (diag == 8'hFA) || (diag == 8'hAA) || (diag == 8'hEE) ||
               (diag == 8'hFE) || (diag == 8'h00) || (diag == 8'hFF);
  end
  // A filtered line only follows the synchronised one after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_f <= 1'b1;
      dat_f <= 1'b1;
      clk_d <= 1'b1;
      clk_c <= '0;
      dat_c <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      clk_d <= clk_f;
      if (clk_s[1] == clk_f) clk_c <= '0;
      else if (clk_c == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_s[1];
        clk_c <= '0;
      end else clk_c <= clk_c + 1'b1;
      if (dat_s[1] == dat_f) dat_c <= '0;
      else if (dat_c == FW'(FILTER_LEN - 1)) begin
        dat_f <= dat_s[1];
        dat_c <= '0;
      end else dat_c <= dat_c + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bcnt       <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      diag       <= '0;
    end else begin
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      tcnt       <= fall ? '0 : (tcnt == TW'(TIMEOUT_CYC) ? tcnt : tcnt + 1'b1);
      if (fall) begin
        if (state == IDLE) begin
          if (!dat_f) begin
            state <= DATA;
            bcnt  <= '0;
          end else rx_err <= 1'b1;
        end else if (state == DATA) begin
          shreg <= {dat_f, shreg[7:1]};
          bcnt  <= bcnt + 1'b1;
          if (bcnt == 3'd7) state <= PARITY;
        end else if (state == PARITY) begin
          par   <= dat_f;
          state <= STOP;
        end else begin
          state <= IDLE;
          if (stop_ok) begin
            byte_valid <= 1'b1;
            diag       <= shreg;
          end else rx_err <= 1'b1;
        end
      end else if (timeout) begin
        rx_err <= 1'b1;
        state  <= IDLE;
      end
    end
  end
  // diag holds the byte just validated, so the byte layer decodes it directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_key <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
      skip    <= '0;
    end else begin
      ps2_key[10] <= 1'b0;
      if (stop_bad) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= '0;
      end else if (byte_valid) begin
        if (skip != 3'd0) begin
          skip <= skip - 1'b1;
          if (skip == 3'd1) ps2_key <= {1'b1, 1'b0, 1'b1, 8'h77};
        end else if (diag == 8'hE1) skip <= 3'd7;
        else if (diag == 8'hE0) ext <= 1'b1;
        else if (diag == 8'hF0) brk <= 1'b1;
        else if (!ignored) begin
          ps2_key <= {1'b1, brk, ext, diag};
          ext     <= 1'b0;
          brk     <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed table-driven bench for the PS/2 scan decoder.
module tb_ps2_scan_decoder;
  localparam int FL = 8;
  localparam int TO = 12500;
  localparam int H  = 20;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        rx_err;
  logic [7:0]  diag;
  int total = 0;
  int bad = 0;
  int nstb = 0;
  int nerr = 0;
  logic [10:0] last_key = '0;
  typedef struct {
    logic [7:0]  b;
    logic        bad_par;
    logic        strobe;
    logic [10:0] key;
    logic        err;
  } vec_t;
  vec_t tab[20];
  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .rx_err(rx_err), .diag(diag)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ps2_key[10]) begin
      nstb++;
      last_key = ps2_key;
    end
    if (rx_err) nerr++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_bits(input int n, input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, bad_par ? ^b : ~^b, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask
  initial begin
    int s0, e0, cyc;
    logic [7:0] exp_diag;
    tab[0]  = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[1]  = '{8'h1C, 1'b0, 1'b1, 11'h61C, 1'b0};
    tab[2]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[3]  = '{8'h75, 1'b0, 1'b1, 11'h575, 1'b0};
    tab[4]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[5]  = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[6]  = '{8'h75, 1'b0, 1'b1, 11'h775, 1'b0};
    tab[7]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[8]  = '{8'h1C, 1'b1, 1'b0, 11'h000, 1'b1};
    tab[9]  = '{8'h1C, 1'b0, 1'b1, 11'h41C, 1'b0};
    tab[10] = '{8'hE1, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[11] = '{8'h14, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[12] = '{8'h77, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[13] = '{8'hE1, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[14] = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[15] = '{8'h14, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[16] = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[17] = '{8'h77, 1'b0, 1'b1, 11'h577, 1'b0};
    tab[18] = '{8'hFA, 1'b0, 1'b0, 11'h000, 1'b0};
    tab[19] = '{8'h5A, 1'b0, 1'b1, 11'h45A, 1'b0};
    repeat (4) @(negedge clk);
    chk("reset_key", 32'(ps2_key), 32'h0);
    chk("reset_err", 32'(rx_err), 32'h0);
    chk("reset_diag", 32'(diag), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    // single make code: watch the strobe cycle and the cycle after it
    s0 = nstb;
    e0 = nerr;
    send_bits(10, 8'h1C, 1'b0);
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    cyc = 0;
    while (!ps2_key[10] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t1_strobe_seen", 32'(cyc < 100), 32'h1);
    chk("t1_key", 32'(ps2_key), 32'h41C);
    @(negedge clk);
    chk("t1_key_next", 32'(ps2_key), 32'h01C);
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    chk("t1_diag", 32'(diag), 32'h1C);
    chk("t1_nstb", 32'(nstb - s0), 32'h1);
    chk("t1_nerr", 32'(nerr - e0), 32'h0);
    exp_diag = 8'h1C;
    for (int i = 0; i < 20; i++) begin
      s0 = nstb;
      e0 = nerr;
      send_bits(11, tab[i].b, tab[i].bad_par);
      repeat (10) @(negedge clk);
      if (!tab[i].bad_par) exp_diag = tab[i].b;
      chk($sformatf("vec%0d_strobe", i), 32'(nstb - s0), 32'(tab[i].strobe));
      chk($sformatf("vec%0d_err", i), 32'(nerr - e0), 32'(tab[i].err));
      chk($sformatf("vec%0d_diag", i), 32'(diag), 32'(exp_diag));
      if (tab[i].strobe) chk($sformatf("vec%0d_key", i), 32'(last_key), 32'(tab[i].key));
    end
    // partial frame abandoned by the idle timeout
    s0 = nstb;
    e0 = nerr;
    send_bits(5, 8'h1C, 1'b0);
    repeat (TO + 10) @(negedge clk);
    chk("to_err", 32'(nerr - e0), 32'h1);
    chk("to_nstb", 32'(nstb - s0), 32'h0);
    s0 = nstb;
    send_bits(11, 8'h1C, 1'b0);
    repeat (10) @(negedge clk);
    chk("to_after_nstb", 32'(nstb - s0), 32'h1);
    chk("to_after_key", 32'(last_key), 32'h41C);
    // short clock glitch must be filtered out
    s0 = nstb;
    e0 = nerr;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_err", 32'(nerr - e0), 32'h0);
    chk("glitch_nstb", 32'(nstb - s0), 32'h0);
    send_bits(11, 8'h1C, 1'b0);
    repeat (10) @(negedge clk);
    chk("glitch_after_nstb", 32'(nstb - s0), 32'h1);
    chk("glitch_after_key", 32'(last_key), 32'h41C);
    // reset in the middle of a frame
    s0 = nstb;
    e0 = nerr;
    send_bits(5, 8'h2B, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rst_key%0d", i), 32'(ps2_key), 32'h0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_bits(11, 8'h2B, 1'b0);
    repeat (10) @(negedge clk);
    chk("rst_nstb", 32'(nstb - s0), 32'h1);
    chk("rst_key_after", 32'(last_key), 32'h42B);
    chk("rst_err", 32'(nerr - e0), 32'h0);
    chk("rst_diag", 32'(diag), 32'h2B);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
